// File: rtl/multicycle_control.sv
// multicycle_control
// Sequencing controller for a multi-cycle RV32I datapath sharing one
// variable-latency memory port between instruction fetch and data access.
// Each instruction steps through FETCH, DECODE, EXECUTE, MEM, WRITEBACK.
//
// state | meaning
// ------+-------------------------------------------------------------
// 0     | FETCH     : read instruction, load IR and PC+4 on mem_ready
// 1     | DECODE    : classify opcode, flag illegal opcodes
// 2     | EXECUTE   : drive ALU; branches resolve and retire here
// 3     | MEM       : load/store data access, held until mem_ready
// 4     | WRITEBACK : register file write, instruction retires
// 5-7   | unreachable, recover to FETCH on the next edge
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   opcode                IR[6:0], used only in DECODE
//   zero                  ALU zero flag, used only in EXECUTE of a branch
//   mem_ready             memory completion, used in FETCH and MEM
//   pc_write, pc_src      PC load strobe and source (0 = PC+4, 1 = target)
//   ir_write              IR load strobe
//   mem_read, mem_write   memory requests
//   mem_to_reg            writeback mux select (1 = memory data)
//   alu_src, alu_op       ALU operand B select and operation class
//   reg_write             register file write enable
//   illegal, retired      single-cycle status pulses
//   state                 current state encoding, for debug
module multicycle_control #(
    parameter int OPCODE_W = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_src,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic                reg_write,
    output logic                illegal,
    output logic                retired,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NONE   = 3'd0,
        C_LOAD   = 3'd1,
        C_STORE  = 3'd2,
        C_BRANCH = 3'd3,
        C_OPIMM  = 3'd4,
        C_OP     = 3'd5
    } class_t;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OPC_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = OPCODE_W'(7'b1100011);
    localparam logic [OPCODE_W-1:0] OPC_OPIMM  = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OPC_OP     = OPCODE_W'(7'b0110011);

    state_t r_state;
    class_t r_class;
    class_t w_dec_class;

    always_comb begin
        w_dec_class = C_NONE;
        case (opcode)
            OPC_LOAD:   w_dec_class = C_LOAD;
            OPC_STORE:  w_dec_class = C_STORE;
            OPC_BRANCH: w_dec_class = C_BRANCH;
            OPC_OPIMM:  w_dec_class = C_OPIMM;
            OPC_OP:     w_dec_class = C_OP;
            default:    w_dec_class = C_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_class <= C_NONE;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_class <= w_dec_class;
                    r_state <= (w_dec_class == C_NONE) ? S_FETCH : S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (r_class)
                        C_LOAD, C_STORE: r_state <= S_MEM;
                        C_OPIMM, C_OP:   r_state <= S_WRITEBACK;
                        default:         r_state <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (r_class != C_LOAD && r_class != C_STORE)
                        r_state <= S_FETCH;
                    else if (mem_ready)
                        r_state <= (r_class == C_LOAD) ? S_WRITEBACK : S_FETCH;
                end
                S_WRITEBACK: r_state <= S_FETCH;
                default:     r_state <= S_FETCH;
            endcase
        end
    end

    // Outputs are decoded from the current state; rst_n gates them so that
    // every strobe, including the FETCH read request, collapses the moment
    // reset asserts rather than waiting for a clock edge.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        retired    = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    illegal = (w_dec_class == C_NONE);
                end
                S_EXECUTE: begin
                    case (r_class)
                        C_LOAD, C_STORE: begin
                            alu_op  = 2'b00;
                            alu_src = 1'b1;
                        end
                        C_OPIMM: begin
                            alu_op  = 2'b10;
                            alu_src = 1'b1;
                        end
                        C_OP: begin
                            alu_op  = 2'b10;
                        end
                        C_BRANCH: begin
                            alu_op   = 2'b01;
                            pc_write = zero;
                            pc_src   = zero;
                            retired  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    // Address operands held so the effective address stays
                    // stable for the whole memory wait.
                    alu_op  = 2'b00;
                    alu_src = 1'b1;
                    if (r_class == C_LOAD) begin
                        mem_read = 1'b1;
                    end else if (r_class == C_STORE) begin
                        mem_write = 1'b1;
                        retired   = mem_ready;
                    end
                end
                S_WRITEBACK: begin
                    reg_write  = 1'b1;
                    retired    = 1'b1;
                    mem_to_reg = (r_class == C_LOAD);
                end
                default: ;
            endcase
        end
    end

    assign state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = 7'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg;
    logic       alu_src, reg_write, illegal, retired;
    logic [1:0] alu_op;
    logic [2:0] state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control #(.OPCODE_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .ir_write  (ir_write),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_to_reg(mem_to_reg),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .reg_write (reg_write),
        .illegal   (illegal),
        .retired   (retired),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Output vector bit order:
    // [11] pc_write [10] pc_src [9] ir_write [8] mem_read [7] mem_write
    // [6] mem_to_reg [5] alu_src [4:3] alu_op [2] reg_write [1] illegal [0] retired
    localparam logic [11:0] O_NONE     = 12'h000;
    localparam logic [11:0] O_F_WAIT   = 12'h100;
    localparam logic [11:0] O_F_RDY    = 12'hB00;
    localparam logic [11:0] O_D_ILL    = 12'h002;
    localparam logic [11:0] O_E_ADDR   = 12'h020;
    localparam logic [11:0] O_E_OPIMM  = 12'h030;
    localparam logic [11:0] O_E_OP     = 12'h010;
    localparam logic [11:0] O_E_BR_T   = 12'hC09;
    localparam logic [11:0] O_E_BR_N   = 12'h009;
    localparam logic [11:0] O_M_LOAD   = 12'h120;
    localparam logic [11:0] O_M_ST     = 12'h0A0;
    localparam logic [11:0] O_M_ST_RDY = 12'h0A1;
    localparam logic [11:0] O_W_LOAD   = 12'h045;
    localparam logic [11:0] O_W_ALU    = 12'h005;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_OPIMM = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic        z;
        logic [2:0]  st;
        logic [11:0] o;
    } row_t;

    function automatic logic [11:0] outs();
        return {pc_write, pc_src, ir_write, mem_read, mem_write, mem_to_reg,
                alu_src, alu_op, reg_write, illegal, retired};
    endfunction

    // Drives one cycle's inputs at the falling edge and settles before sampling.
    task automatic apply(input row_t r);
        @(negedge clk);
        opcode    = r.op;
        mem_ready = r.rdy;
        zero      = r.z;
        #1;
    endtask

    task automatic test_reset();
        opcode    = OP_R;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (outs() !== O_NONE) begin
                n_errors++;
                $display("FAIL reset_outs[%0d]: got %h want %h", i, outs(), O_NONE);
            end
            n_checks++;
            if (state !== 3'd0) begin
                n_errors++;
                $display("FAIL reset_state[%0d]: got %0d want 0", i, state);
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        n_checks++;
        if (outs() !== O_F_WAIT) begin
            n_errors++;
            $display("FAIL release_outs: got %h want %h", outs(), O_F_WAIT);
        end
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("FAIL release_state: got %0d want 0", state);
        end
    endtask

    task automatic test_rtype();
        row_t rows[$];
        rows.push_back(row_t'{OP_BAD, 1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_R,   1'b0, 1'b1, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_BAD, 1'b1, 1'b1, 3'd2, O_E_OP});
        rows.push_back(row_t'{OP_LOAD,1'b1, 1'b0, 3'd4, O_W_ALU});
        rows.push_back(row_t'{OP_R,   1'b0, 1'b0, 3'd0, O_F_WAIT});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL rtype_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
    endtask

    task automatic test_opimm();
        row_t rows[$];
        rows.push_back(row_t'{OP_R,     1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_OPIMM, 1'b0, 1'b0, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_STORE, 1'b0, 1'b0, 3'd2, O_E_OPIMM});
        rows.push_back(row_t'{OP_LOAD,  1'b0, 1'b0, 3'd4, O_W_ALU});
        rows.push_back(row_t'{OP_OPIMM, 1'b0, 1'b0, 3'd0, O_F_WAIT});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL opimm_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL opimm_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
    endtask

    // Two FETCH waits plus three MEM waits: 10 cycles before the next FETCH.
    task automatic test_load_waits();
        row_t rows[$];
        rows.push_back(row_t'{OP_BAD,  1'b0, 1'b0, 3'd0, O_F_WAIT});
        rows.push_back(row_t'{OP_BAD,  1'b0, 1'b0, 3'd0, O_F_WAIT});
        rows.push_back(row_t'{OP_BAD,  1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_LOAD, 1'b1, 1'b0, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_R,    1'b1, 1'b0, 3'd2, O_E_ADDR});
        rows.push_back(row_t'{OP_R,    1'b0, 1'b1, 3'd3, O_M_LOAD});
        rows.push_back(row_t'{OP_R,    1'b0, 1'b0, 3'd3, O_M_LOAD});
        rows.push_back(row_t'{OP_R,    1'b0, 1'b0, 3'd3, O_M_LOAD});
        rows.push_back(row_t'{OP_R,    1'b1, 1'b0, 3'd3, O_M_LOAD});
        rows.push_back(row_t'{OP_R,    1'b0, 1'b0, 3'd4, O_W_LOAD});
        rows.push_back(row_t'{OP_R,    1'b0, 1'b0, 3'd0, O_F_WAIT});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL load_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL load_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
    endtask

    task automatic test_branch();
        row_t rows[$];
        // taken: zero is toggled outside EXECUTE to show it is ignored there
        rows.push_back(row_t'{OP_R,  1'b1, 1'b1, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_BR, 1'b0, 1'b1, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_R,  1'b1, 1'b1, 3'd2, O_E_BR_T});
        rows.push_back(row_t'{OP_BR, 1'b0, 1'b1, 3'd0, O_F_WAIT});
        // not taken
        rows.push_back(row_t'{OP_BR, 1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_BR, 1'b0, 1'b0, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_BR, 1'b1, 1'b0, 3'd2, O_E_BR_N});
        rows.push_back(row_t'{OP_BR, 1'b0, 1'b1, 3'd0, O_F_WAIT});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL branch_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL branch_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
    endtask

    task automatic test_store();
        row_t rows[$];
        rows.push_back(row_t'{OP_R,     1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_STORE, 1'b0, 1'b0, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_LOAD,  1'b1, 1'b0, 3'd2, O_E_ADDR});
        rows.push_back(row_t'{OP_LOAD,  1'b0, 1'b0, 3'd3, O_M_ST});
        rows.push_back(row_t'{OP_LOAD,  1'b0, 1'b0, 3'd3, O_M_ST});
        rows.push_back(row_t'{OP_LOAD,  1'b1, 1'b0, 3'd3, O_M_ST_RDY});
        rows.push_back(row_t'{OP_LOAD,  1'b0, 1'b0, 3'd0, O_F_WAIT});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL store_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL store_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
    endtask

    task automatic test_illegal();
        row_t rows[$];
        rows.push_back(row_t'{OP_R,   1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_BAD, 1'b1, 1'b1, 3'd1, O_D_ILL});
        rows.push_back(row_t'{OP_BAD, 1'b0, 1'b1, 3'd0, O_F_WAIT});
        rows.push_back(row_t'{OP_BAD, 1'b0, 1'b0, 3'd0, O_F_WAIT});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL illegal_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL illegal_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        row_t rows[$];
        rows.push_back(row_t'{OP_R,     1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_STORE, 1'b0, 1'b0, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_R,     1'b0, 1'b0, 3'd2, O_E_ADDR});
        rows.push_back(row_t'{OP_R,     1'b0, 1'b0, 3'd3, O_M_ST});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL midrst_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL midrst_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
        // still inside the low clock phase: no edge occurs before the check
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (outs() !== O_NONE) begin
            n_errors++;
            $display("FAIL midrst_async_outs: got %h want %h", outs(), O_NONE);
        end
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("FAIL midrst_async_state: got %0d want 0", state);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("FAIL midrst_release_state: got %0d want 0", state);
        end
        n_checks++;
        if (outs() !== O_F_WAIT) begin
            n_errors++;
            $display("FAIL midrst_release_outs: got %h want %h", outs(), O_F_WAIT);
        end
    endtask

    // Store abandoned by reset must not leak its class into the next instruction.
    task automatic test_back_to_back();
        row_t rows[$];
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_OPIMM, 1'b1, 1'b0, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd2, O_E_OPIMM});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd4, O_W_ALU});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_LOAD,  1'b1, 1'b0, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd2, O_E_ADDR});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd3, O_M_LOAD});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd4, O_W_LOAD});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b0, 3'd0, O_F_RDY});
        rows.push_back(row_t'{OP_BR,    1'b1, 1'b1, 3'd1, O_NONE});
        rows.push_back(row_t'{OP_BAD,   1'b1, 1'b1, 3'd2, O_E_BR_T});
        rows.push_back(row_t'{OP_BAD,   1'b0, 1'b0, 3'd0, O_F_WAIT});
        foreach (rows[i]) begin
            apply(rows[i]);
            n_checks++;
            if (state !== rows[i].st) begin
                n_errors++;
                $display("FAIL b2b_state[%0d]: got %0d want %0d", i, state, rows[i].st);
            end
            n_checks++;
            if (outs() !== rows[i].o) begin
                n_errors++;
                $display("FAIL b2b_outs[%0d]: got %h want %h", i, outs(), rows[i].o);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_opimm();
        test_load_waits();
        test_branch();
        test_store();
        test_illegal();
        test_reset_mid_mem();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
